// File: rtl/pixel_unpacker_pkg.sv
// Shared types and constants for the pixel unpacker: FSM state encoding,
// RGB byte-lane positions inside a 24-bit pixel word, and a lane selector.
package pixel_unpacker_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    LATCH  = 4'd2,
    SEND_R = 4'd3,
    WAIT_R = 4'd4,
    SEND_G = 4'd5,
    WAIT_G = 4'd6,
    SEND_B = 4'd7,
    WAIT_B = 4'd8,
    DONE   = 4'd9
  } state_e;

  localparam int R_MSB = 23;
  localparam int G_MSB = 15;
  localparam int B_MSB = 7;

  // Extract the 8-bit lane whose top bit sits at position msb.
  function automatic logic [7:0] pick_byte(input logic [23:0] px, input int msb);
    return px[msb -: 8];
  endfunction

endpackage

// File: rtl/pixel_unpacker.sv
// Pixel unpacker: pops 24-bit RGB words from a FIFO and streams them to a
// UART transmitter as three bytes (R, G, B), N_PIXELS pixels per frame.
module pixel_unpacker
  import pixel_unpacker_pkg::*;
#(
  parameter int N_PIXELS = 16384,
  parameter int CNT_W    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        fifo_empty,
  input  logic [23:0] fifo_dout,
  output logic        fifo_rd_en,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frame_done
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               resolve_q, resolve_d;
  logic [23:0]        pixel_q, pixel_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;

  // State register plus counter, pixel and UART-side output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      resolve_q  <= 1'b0;
      pixel_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      resolve_q  <= resolve_d;
      pixel_q    <= pixel_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Next-state logic, including the pixel counter and the WAIT_B resolve phase
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    resolve_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // Stall here indefinitely while the FIFO is empty.
        if (!fifo_empty) state_d = LATCH;
      end
      LATCH:  state_d = SEND_R;
      SEND_R: if (!tx_busy) state_d = WAIT_R;
      // The WAIT cycle is the one in which the byte strobe is visible to the
      // UART; its busy flag lags the strobe, so it is not sampled here. The
      // following SEND state holds off until the transmitter is free.
      WAIT_R: state_d = SEND_G;
      SEND_G: if (!tx_busy) state_d = WAIT_G;
      WAIT_G: state_d = SEND_B;
      SEND_B: if (!tx_busy) state_d = WAIT_B;
      WAIT_B: begin
        // Guard cycle bumps the counter; the extra resolve cycle compares it.
        if (!resolve_q) begin
          count_d   = count_q + CNT_W'(1);
          resolve_d = 1'b1;
        end else if (count_q == CNT_W'(N_PIXELS)) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture the popped pixel and register the outgoing byte/strobe
  always_comb begin
    pixel_d    = pixel_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    unique case (state_q)
      LATCH: pixel_d = fifo_dout;
      SEND_R: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = pick_byte(pixel_q, R_MSB);
        end
      end
      SEND_G: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = pick_byte(pixel_q, G_MSB);
        end
      end
      SEND_B: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = pick_byte(pixel_q, B_MSB);
        end
      end
      default: begin
        pixel_d = pixel_q;
      end
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    busy       = (state_q != IDLE);
    fifo_rd_en = (state_q == FETCH) && !fifo_empty;
    frame_done = (state_q == DONE);
    tx_start   = tx_start_q;
    tx_data    = tx_data_q;
  end

endmodule

// File: tb/tb_pixel_unpacker.sv
// Self-checking bench for pixel_unpacker: FIFO and UART models around a
// two-pixel instance, plus a one-pixel instance for exact frame timing.
module tb_pixel_unpacker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [23:0] fifo_dout = 24'h0;
  logic        fifo_rd_en;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        frame_done;

  logic        start1 = 1'b0;
  logic        fifo_empty1 = 1'b0;
  logic [23:0] fifo_dout1 = 24'hC0FFEE;
  logic        tx_busy1 = 1'b0;
  logic        fifo_rd_en1;
  logic        tx_start1;
  logic [7:0]  tx_data1;
  logic        busy1;
  logic        frame_done1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  logic prev_tx = 1'b0, prev_rd = 1'b0, prev_done = 1'b0;

  logic [23:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  int          strobe_cyc[$];

  logic auto_busy = 1'b0;
  logic force_busy = 1'b0;
  int   busy_cnt = 0;

  pixel_unpacker #(.N_PIXELS(2), .CNT_W(15)) u_dut (
    .clk(clk), .reset(reset), .start(start), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .frame_done(frame_done)
  );

  pixel_unpacker #(.N_PIXELS(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .fifo_empty(fifo_empty1),
    .fifo_dout(fifo_dout1), .fifo_rd_en(fifo_rd_en1), .tx_busy(tx_busy1),
    .tx_start(tx_start1), .tx_data(tx_data1), .busy(busy1), .frame_done(frame_done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: word appears on fifo_dout the cycle after the pop
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) begin
      fifo_dout <= fifo_q[0];
      fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // UART model: busy for 10 cycles after each strobe when auto mode is on
  always @(posedge clk) begin
    if (auto_busy && tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  // Monitor and scoreboard for the two-pixel instance
  always @(negedge clk) begin
    if (tx_start) begin
      tx_cnt = tx_cnt + 1;
      strobe_cyc.push_back(cyc);
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL tx_byte: got %02h, required no strobe", tx_data);
      end else begin
        if (tx_data !== exp_q[0]) begin
          errors = errors + 1;
          $display("FAIL tx_byte: got %02h, required %02h", tx_data, exp_q[0]);
        end else begin
          $display("tx byte %02h at cycle %0d", tx_data, cyc);
        end
        exp_q.pop_front();
      end
    end
    if (fifo_rd_en) rd_cnt = rd_cnt + 1;
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      $display("frame_done at cycle %0d", cyc);
    end
    if ((tx_start && prev_tx) || (fifo_rd_en && prev_rd) || (frame_done && prev_done)) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL pulse_width: tx/rd/done=%b%b%b twice in a row, required single-cycle",
               tx_start, fifo_rd_en, frame_done);
    end
    prev_tx = tx_start;
    prev_rd = fifo_rd_en;
    prev_done = frame_done;
  end

  task automatic push_word(input logic [23:0] w, input bit expect_it);
    fifo_q.push_back(w);
    if (expect_it) begin
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: frame_done=0 after %0d cycles, required 1", tag, budget);
    end
  endtask

  task automatic wait_strobe(input int budget, input string tag);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1;
    end
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: tx_start=0 after %0d cycles, required 1", tag, budget);
    end
  endtask

  task automatic check_frame(input int tx0, input int rd0, input int d0, input string tag);
    repeat (5) @(negedge clk);
    checks = checks + 4;
    if (tx_cnt - tx0 !== 6) begin
      errors++; $display("FAIL %s_tx_count: got %0d, required 6", tag, tx_cnt - tx0);
    end
    if (rd_cnt - rd0 !== 2) begin
      errors++; $display("FAIL %s_rd_count: got %0d, required 2", tag, rd_cnt - rd0);
    end
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL %s_done_count: got %0d, required 1", tag, done_cnt - d0);
    end
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL %s_idle: busy=%b pending=%0d, required busy=0 pending=0",
                         tag, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    start1 = 1'b1;
    repeat (3) @(negedge clk);
    checks = checks + 3;
    if (busy !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b/%b, required 0/0", busy, busy1);
    end
    if (tx_start !== 1'b0 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: tx/rd/done=%b%b%b, required 000",
                         tx_start, fifo_rd_en, frame_done);
    end
    if (tx_data !== 8'h00 || tx_data1 !== 8'h00) begin
      errors++; $display("FAIL reset_tx_data: got %02h/%02h, required 00/00", tx_data, tx_data1);
    end
    start = 1'b0;
    start1 = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks = checks + 1;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_two_pixels();
    int tx0 = tx_cnt, rd0 = rd_cnt, d0 = done_cnt;
    auto_busy = 1'b1;
    push_word(24'hFF8000, 1);
    push_word(24'h0A0B0C, 1);
    @(negedge clk);
    pulse_start();
    wait_done(400, "two_pixels");
    check_frame(tx0, rd0, d0, "two_pixels");
  endtask

  task automatic test_fifo_stall();
    int tx0 = tx_cnt, rd0 = rd_cnt, d0 = done_cnt;
    bit bad = 0;
    auto_busy = 1'b1;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_en || tx_start || !busy) bad = 1;
    end
    checks = checks + 1;
    if (bad) begin
      errors++; $display("FAIL stall_quiet: rd/tx activity or busy drop during empty FIFO, required none");
    end
    push_word(24'h123456, 1);
    push_word(24'h789ABC, 1);
    wait_done(400, "stall");
    check_frame(tx0, rd0, d0, "stall");
  endtask

  task automatic test_send_hold();
    int tx0 = tx_cnt, rd0 = rd_cnt, d0 = done_cnt;
    bit bad = 0;
    auto_busy = 1'b0;
    force_busy = 1'b0;
    push_word(24'h3C7E99, 1);
    push_word(24'h102030, 1);
    @(negedge clk);
    pulse_start();
    wait_strobe(50, "hold_first_byte");
    force_busy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_start || tx_data !== 8'h3C || !busy) bad = 1;
    end
    checks = checks + 1;
    if (bad) begin
      errors++; $display("FAIL send_hold: tx_start=%b tx_data=%02h, required 0 and 3c throughout",
                         tx_start, tx_data);
    end
    force_busy = 1'b0;
    wait_done(200, "send_hold");
    check_frame(tx0, rd0, d0, "send_hold");
  endtask

  task automatic test_reset_midframe();
    int d0 = done_cnt;
    int tx0, rd0;
    auto_busy = 1'b1;
    push_word(24'hA1B2C3, 1);
    push_word(24'hD4E5F6, 0);
    @(negedge clk);
    pulse_start();
    wait_strobe(50, "midframe_first_byte");
    reset = 1'b0;
    @(negedge clk);
    checks = checks + 2;
    if (busy !== 1'b0 || tx_start !== 1'b0 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: busy/tx/rd/done=%b%b%b%b, required 0000",
                         busy, tx_start, fifo_rd_en, frame_done);
    end
    if (tx_data !== 8'h00) begin
      errors++; $display("FAIL midreset_tx_data: got %02h, required 00", tx_data);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks = checks + 2;
    if (done_cnt !== d0) begin
      errors++; $display("FAIL midreset_no_done: got %0d frame_done, required 0", done_cnt - d0);
    end
    if (fifo_q.size() != 1) begin
      errors++; $display("FAIL midreset_fifo_level: got %0d words, required 1", fifo_q.size());
    end
    exp_q.delete();
    exp_q.push_back(8'hD4);
    exp_q.push_back(8'hE5);
    exp_q.push_back(8'hF6);
    push_word(24'h0F1E2D, 1);
    tx0 = tx_cnt; rd0 = rd_cnt; d0 = done_cnt;
    @(negedge clk);
    pulse_start();
    wait_done(400, "midreset_restart");
    check_frame(tx0, rd0, d0, "midreset_restart");
  endtask

  task automatic test_start_ignored();
    int tx0 = tx_cnt, rd0 = rd_cnt, d0 = done_cnt;
    bit seen = 0;
    bit bad = 0;
    auto_busy = 1'b0;
    force_busy = 1'b0;
    push_word(24'h445566, 1);
    push_word(24'h778899, 1);
    @(negedge clk);
    strobe_cyc.delete();
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks = checks + 1;
    if (!seen) begin
      errors++; $display("FAIL ignore_done_seen: frame_done=0 after 100 cycles, required 1");
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || tx_start || fifo_rd_en) bad = 1;
    end
    checks = checks + 1;
    if (bad) begin
      errors++; $display("FAIL ignore_restart: activity after DONE-cycle start, required idle");
    end
    checks = checks + 2;
    if (strobe_cyc.size() != 6 || strobe_cyc[1] - strobe_cyc[0] != 2) begin
      errors++; $display("FAIL byte_spacing: strobes=%0d gap=%0d, required 6 and 2",
                         strobe_cyc.size(), strobe_cyc.size() > 1 ? strobe_cyc[1] - strobe_cyc[0] : -1);
    end
    if (strobe_cyc.size() < 4 || strobe_cyc[3] - strobe_cyc[0] != 9) begin
      errors++; $display("FAIL pixel_spacing: got %0d cycles, required 9",
                         strobe_cyc.size() > 3 ? strobe_cyc[3] - strobe_cyc[0] : -1);
    end
    check_frame(tx0, rd0, d0, "ignore");
  endtask

  task automatic test_single_pixel_timing();
    int          got_k[$];
    logic [7:0]  got_b[$];
    int          exp_k[$];
    logic [7:0]  exp_b[$];
    int          rd_k = -1;
    int          done_k = -1;
    int          done_n = 0;
    exp_k = '{4, 6, 8};
    exp_b = '{8'hC0, 8'hFF, 8'hEE};
    start1 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (fifo_rd_en1) rd_k = k;
      if (tx_start1) begin
        got_k.push_back(k);
        got_b.push_back(tx_data1);
      end
      if (frame_done1) begin
        done_k = k;
        done_n++;
      end
    end
    checks = checks + 3;
    if (rd_k != 1) begin
      errors++; $display("FAIL single_rd_cycle: got %0d, required 1", rd_k);
    end
    if (done_k != 10 || done_n != 1) begin
      errors++; $display("FAIL single_done_cycle: got %0d (x%0d), required 10 (x1)", done_k, done_n);
    end
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL single_busy_after: got %b, required 0", busy1);
    end
    checks = checks + 1;
    if (got_k.size() != 3) begin
      errors++; $display("FAIL single_strobe_count: got %0d, required 3", got_k.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks = checks + 1;
        if (got_k[i] != exp_k[i] || got_b[i] !== exp_b[i]) begin
          errors++; $display("FAIL single_strobe%0d: got %02h at %0d, required %02h at %0d",
                             i, got_b[i], got_k[i], exp_b[i], exp_k[i]);
        end else begin
          $display("single-pixel byte %02h at cycle %0d", got_b[i], got_k[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_pixels();
    test_fifo_stall();
    test_send_hold();
    test_reset_midframe();
    test_start_ignored();
    test_single_pixel_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
